// File: rtl/control_unit_pkg.sv
// Shared encodings for the instruction decoder: opcodes, control-field enums and the
// packed control word carried from decode to the output register.
package control_unit_pkg;

   typedef enum logic [5:0] {
      OpNop   = 6'h00,
      OpAdd   = 6'h01,
      OpSub   = 6'h02,
      OpAnd   = 6'h03,
      OpOr    = 6'h04,
      OpAddi  = 6'h05,
      OpSubi  = 6'h06,
      OpAndi  = 6'h07,
      OpOri   = 6'h08,
      OpLoad  = 6'h09,
      OpStore = 6'h0A,
      OpLi    = 6'h0B,
      OpBeq   = 6'h0C,
      OpJmp   = 6'h0D,
      OpCall  = 6'h0E,
      OpRet   = 6'h0F,
      OpPush  = 6'h10,
      OpPop   = 6'h11,
      OpHalt  = 6'h12
   } opcode_e;

   typedef enum logic [1:0] {
      PcInc    = 2'b00,
      PcBranch = 2'b01,
      PcJump   = 2'b10,
      PcStack  = 2'b11
   } pc_sel_e;

   typedef enum logic [1:0] {
      AluAdd = 2'b00,
      AluSub = 2'b01,
      AluAnd = 2'b10,
      AluOr  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      SrcReg  = 2'b00,
      SrcSext = 2'b01,
      SrcZext = 2'b10,
      SrcZero = 2'b11
   } alu_src_e;

   typedef enum logic [1:0] {
      WbAlu   = 2'b00,
      WbMem   = 2'b01,
      WbImm   = 2'b10,
      WbStack = 2'b11
   } wb_sel_e;

   typedef struct packed {
      logic     stack_control;
      logic     pc_inc;
      pc_sel_e  pc_sel;
      logic     gr_we;
      logic     stack_we;
      logic     wdata_rt;
      alu_src_e alu_src2;
      alu_op_e  alu_op;
      logic     branch;
      logic     mem_we;
      wb_sel_e  wb_sel;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_RESET = '{
      stack_control: 1'b0,
      pc_inc:        1'b0,
      pc_sel:        PcInc,
      gr_we:         1'b0,
      stack_we:      1'b0,
      wdata_rt:      1'b0,
      alu_src2:      SrcReg,
      alu_op:        AluAdd,
      branch:        1'b0,
      mem_we:        1'b0,
      wb_sel:        WbAlu
   };

   localparam ctrl_word_t CTRL_NOP = '{
      stack_control: 1'b0,
      pc_inc:        1'b1,
      pc_sel:        PcInc,
      gr_we:         1'b0,
      stack_we:      1'b0,
      wdata_rt:      1'b0,
      alu_src2:      SrcReg,
      alu_op:        AluAdd,
      branch:        1'b0,
      mem_we:        1'b0,
      wb_sel:        WbAlu
   };

   // Register-file write through the ALU with the given operand source and operation.
   function automatic ctrl_word_t alu_word(alu_src_e src, alu_op_e op);
      ctrl_word_t w;
      w          = CTRL_NOP;
      w.gr_we    = 1'b1;
      w.alu_src2 = src;
      w.alu_op   = op;
      return w;
   endfunction

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode decoder producing one control word per opcode.
module control_decode
   import control_unit_pkg::*;
(
   input  logic [5:0] opcode_i,
   output ctrl_word_t ctrl_o
);

   always_comb begin
      ctrl_o = CTRL_NOP;
      // Undefined or unknown opcodes fall to the default and never raise a write enable.
      unique case (opcode_i)
         OpNop:   ctrl_o = CTRL_NOP;
         OpAdd:   ctrl_o = alu_word(SrcReg, AluAdd);
         OpSub:   ctrl_o = alu_word(SrcReg, AluSub);
         OpAnd:   ctrl_o = alu_word(SrcReg, AluAnd);
         OpOr:    ctrl_o = alu_word(SrcReg, AluOr);
         OpAddi:  ctrl_o = alu_word(SrcSext, AluAdd);
         OpSubi:  ctrl_o = alu_word(SrcSext, AluSub);
         OpAndi:  ctrl_o = alu_word(SrcZext, AluAnd);
         OpOri:   ctrl_o = alu_word(SrcZext, AluOr);
         OpLoad: begin
            ctrl_o        = alu_word(SrcSext, AluAdd);
            ctrl_o.wb_sel = WbMem;
         end
         OpStore: begin
            ctrl_o.mem_we   = 1'b1;
            ctrl_o.wdata_rt = 1'b1;
            ctrl_o.alu_src2 = SrcSext;
            ctrl_o.alu_op   = AluAdd;
         end
         OpLi: begin
            ctrl_o.gr_we  = 1'b1;
            ctrl_o.wb_sel = WbImm;
         end
         OpBeq: begin
            ctrl_o.branch   = 1'b1;
            ctrl_o.pc_sel   = PcBranch;
            ctrl_o.alu_src2 = SrcReg;
            ctrl_o.alu_op   = AluSub;
         end
         OpJmp: ctrl_o.pc_sel = PcJump;
         OpCall: begin
            // Return address (PC+1) goes onto the stack.
            ctrl_o.pc_sel        = PcJump;
            ctrl_o.stack_control = 1'b1;
            ctrl_o.stack_we      = 1'b1;
            ctrl_o.wdata_rt      = 1'b0;
         end
         OpRet: begin
            ctrl_o.pc_sel        = PcStack;
            ctrl_o.stack_control = 1'b1;
         end
         OpPush: begin
            ctrl_o.stack_control = 1'b1;
            ctrl_o.stack_we      = 1'b1;
            ctrl_o.wdata_rt      = 1'b1;
         end
         OpPop: begin
            ctrl_o.stack_control = 1'b1;
            ctrl_o.gr_we         = 1'b1;
            ctrl_o.wb_sel        = WbStack;
         end
         OpHalt:  ctrl_o = CTRL_RESET;
         default: ctrl_o = CTRL_NOP;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Main instruction decoder: decodes the opcode and registers the control word for the
// datapath; reset clears every output, freezing the PC.
module control_unit
   import control_unit_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   output logic       stack_control,
   output logic       pc_increment_control,
   output logic [1:0] pc_control,
   output logic       general_register_write_enable,
   output logic       stack_write_enable,
   output logic       write_data_enable,
   output logic [1:0] ALU_source_2,
   output logic [1:0] ALU_control,
   output logic       branch,
   output logic       memory_write_enable,
   output logic [1:0] general_register_result_select
);

   ctrl_word_t ctrl_d;
   ctrl_word_t ctrl_q;

   control_decode u_decode (
      .opcode_i (opcode),
      .ctrl_o   (ctrl_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= CTRL_RESET;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign stack_control                  = ctrl_q.stack_control;
   assign pc_increment_control           = ctrl_q.pc_inc;
   assign pc_control                     = ctrl_q.pc_sel;
   assign general_register_write_enable  = ctrl_q.gr_we;
   assign stack_write_enable             = ctrl_q.stack_we;
   assign write_data_enable              = ctrl_q.wdata_rt;
   assign ALU_source_2                   = ctrl_q.alu_src2;
   assign ALU_control                    = ctrl_q.alu_op;
   assign branch                         = ctrl_q.branch;
   assign memory_write_enable            = ctrl_q.mem_we;
   assign general_register_result_select = ctrl_q.wb_sel;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a table-driven reference model predicts each control
// word, a driver queues expectations and a monitor compares one edge later.
module tb_control_unit;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       stack_control;
   logic       pc_increment_control;
   logic [1:0] pc_control;
   logic       general_register_write_enable;
   logic       stack_write_enable;
   logic       write_data_enable;
   logic [1:0] ALU_source_2;
   logic [1:0] ALU_control;
   logic       branch;
   logic       memory_write_enable;
   logic [1:0] general_register_result_select;

   control_unit dut (
      .clk                            (clk),
      .rst_n                          (rst_n),
      .opcode                         (opcode),
      .stack_control                  (stack_control),
      .pc_increment_control           (pc_increment_control),
      .pc_control                     (pc_control),
      .general_register_write_enable  (general_register_write_enable),
      .stack_write_enable             (stack_write_enable),
      .write_data_enable              (write_data_enable),
      .ALU_source_2                   (ALU_source_2),
      .ALU_control                    (ALU_control),
      .branch                         (branch),
      .memory_write_enable            (memory_write_enable),
      .general_register_result_select (general_register_result_select)
   );

   // Field order: sc, pc_inc, pc_ctl, gr_we, stk_we, wde, src2, alu, br, mem_we, res_sel
   logic [14:0] dut_w;
   assign dut_w = {stack_control, pc_increment_control, pc_control,
                   general_register_write_enable, stack_write_enable, write_data_enable,
                   ALU_source_2, ALU_control, branch, memory_write_enable,
                   general_register_result_select};

   typedef struct {
      logic [5:0]  op;
      logic [14:0] w;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] model(input logic [5:0] op);
      logic       sc, pinc, gwe, swe, wde, br, mwe;
      logic [1:0] pcs, src, alu, res;
      int         n;
      sc = 0; pinc = 1; gwe = 0; swe = 0; wde = 0; br = 0; mwe = 0;
      pcs = 0; src = 0; alu = 0; res = 0;
      n = $isunknown(op) ? 0 : int'(op);
      if (n >= 1 && n <= 4) begin
         gwe = 1; alu = 2'(n - 1);
      end else if (n >= 5 && n <= 8) begin
         gwe = 1; alu = 2'(n - 5); src = (n <= 6) ? 2'd1 : 2'd2;
      end else begin
         case (n)
            9:  begin gwe = 1; src = 1; res = 1; end
            10: begin mwe = 1; wde = 1; src = 1; end
            11: begin gwe = 1; res = 2; end
            12: begin br = 1; pcs = 1; alu = 1; end
            13: pcs = 2;
            14: begin pcs = 2; sc = 1; swe = 1; end
            15: begin pcs = 3; sc = 1; end
            16: begin sc = 1; swe = 1; wde = 1; end
            17: begin sc = 1; gwe = 1; res = 3; end
            18: pinc = 0;
            default: ;
         endcase
      end
      return {sc, pinc, pcs, gwe, swe, wde, src, alu, br, mwe, res};
   endfunction

   task automatic check(input string name, input logic [14:0] act, input logic [14:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %015b expected %015b", name, act, req);
      end
   endtask

   task automatic issue_now(input logic [5:0] op);
      exp_t e;
      opcode = op;
      e.op   = op;
      e.w    = model(op);
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [5:0] op);
      @(negedge clk);
      issue_now(op);
   endtask

   // Monitor: every edge out of reset presents the word for the opcode queued before it.
   always @(posedge clk) begin
      #1;
      if (rst_n && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check($sformatf("op_%02h", e.op), dut_w, e.w);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         n_cmp++;
         if (memory_write_enable && stack_write_enable) begin
            n_bad++;
            $display("FAIL excl_we: mem_we=%0b stack_we=%0b required not both 1",
                     memory_write_enable, stack_write_enable);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running, required to finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] undef_ops [3];
      undef_ops = '{6'h13, 6'h2A, 6'h3F};
      rst_n  = 1'b1;
      opcode = 6'h01;
      #1 rst_n = 1'b0;
      #1 check("rst_async", dut_w, 15'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 check("rst_hold", dut_w, 15'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int op = 0; op <= 'h12; op++) issue(6'(op));
      issue(6'h12);
      issue(6'h12);
      issue(6'h00);
      foreach (undef_ops[i]) issue(undef_ops[i]);
      issue(6'bxxxxxx);
      issue(6'h00);
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) issue(6'($urandom_range(0, 63)));
         else issue(6'($urandom_range(0, 'h12)));
      end

      // Reset between edges discards the registered STORE word at once.
      issue(6'h0A);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("rst_mid", dut_w, 15'd0);
      @(posedge clk);
      #1 check("rst_mid_hold", dut_w, 15'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue_now(6'h09);
      issue(6'h0E);
      issue(6'h12);

      @(posedge clk);
      @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d words left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
